mul_pipe: RTL and testbench
===========================

MUL_PIPE -- requirements
Module: mul_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width (even, >=8).
REQ-002 SHALL have parameter LATENCY, default 3, cycles from input accept to output valid (1..6).
REQ-003 SHALL have parameter TAG_W, default 5, width of passthrough tag (e.g. destination register).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-008 SHALL have ports a, b  input  XLEN  operands.
REQ-009 SHALL have port mulop  input  3  func_types encoding: mul_op, mul_op_h, mul_op_hsu, mul_op_hu.
REQ-010 SHALL have port in_tag  input  TAG_W  opaque tag.
REQ-011 SHALL have port flush  input  1  discard all in-flight requests.
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-014 SHALL have ports f  output  XLEN and out_tag  output  TAG_W, result and tag of the request.

Function
REQ-015 Operands SHALL be extended to XLEN+1 bits: mul_op_hu zero-extends both; mul_op_hsu sign-extends a, zero-extends b; mul_op and mul_op_h sign-extend both.
REQ-016 f SHALL be product[XLEN-1:0] for mul_op, else product[2*XLEN-1:XLEN]; unlisted mulop codes SHALL behave as mul_op_h.
REQ-017 Pipeline SHALL be LATENCY stages, each holding valid, tag, select and partial product; the product may be split across stages freely, but f SHALL depend only on the request's own operands.
REQ-018 Stall SHALL be out_valid && !out_ready; while stalled no stage advances and f/out_tag hold stable.
REQ-019 in_ready SHALL equal !stall (combinational); requests accepted back-to-back at one per cycle when unstalled.
REQ-020 Accepted request SHALL appear at output exactly LATENCY unstalled cycles later; order SHALL be preserved, no drop or duplication.
REQ-021 flush SHALL clear every stage valid on the next edge, including a stalled output; a request presented in the flush cycle SHALL NOT be accepted (in_ready=0 while flush=1).
REQ-022 With no in-flight request, out_valid SHALL be 0 and f/out_tag SHALL hold their last values.
REQ-023 Signed overflow SHALL wrap (mod 2^(2*XLEN)); no exception output.

Reset
REQ-024 While rst_n=0 at a clock edge all stage valids SHALL clear; out_valid=0, in_ready=1, f=0, out_tag=0 after that edge.
REQ-025 Reset mid-operation SHALL discard in-flight requests; reset SHALL take priority over flush and handshakes.

Configuration
REQ-026 Macro MUL_PIPE_REUSE_EN SHALL gate a result-reuse path.
REQ-027 With MUL_PIPE_REUSE_EN defined: block SHALL store a, b, operand-extension class and full 2*XLEN product of the last completed request; a new request accepted while no stage is valid, with identical a, b and class (mul_op/mul_op_h share a class), SHALL produce out_valid on the next cycle (latency 1) with the selected half; flush and reset SHALL invalidate the stored entry.
REQ-028 Without MUL_PIPE_REUSE_EN: no reuse storage; every request takes LATENCY cycles.

Verification
REQ-029 XLEN=32, LATENCY=3: a=0xFFFFFFFF, b=0xFFFFFFFF, mul_op_h -> f=0x00000000; mul_op_hu -> f=0xFFFFFFFE; mul_op_hsu -> f=0xFFFFFFFF; mul_op -> f=0x00000001, each 3 cycles after accept.
REQ-030 a=0x80000000, b=0x80000000, mul_op_h -> f=0x40000000; a=0x80000000, b=0xFFFFFFFF, mul_op_h -> f=0x00000000, mul_op -> f=0x80000000.
REQ-031 Five back-to-back requests tags 1..5, out_ready held 0 for 4 cycles after first out_valid -> in_ready=0 during stall, f/out_tag stable, then tags 1..5 in order, one per cycle.
REQ-032 Three requests in flight, flush pulsed -> out_valid=0 next cycle, no result for those tags; request issued the following cycle returns after 3 cycles.
REQ-033 rst_n=0 for one edge with two requests in flight -> out_valid=0, f=0, out_tag=0; no stale result emerges afterwards.
REQ-034 With MUL_PIPE_REUSE_EN: mul_op_h a=7, b=-3 completes, then idle mul_op same operands -> f=0xFFFFFFEB one cycle after accept; without macro -> same f after 3 cycles.

Source files
------------

// File: rtl/mul_pipe.sv
// Pipelined XLEN x XLEN multiplier (low/high/hsu/hu) with valid/ready handshake, tag passthrough and flush.
// Optional result-reuse path for repeated operands when idle: define MUL_PIPE_REUSE_EN.
module mul_pipe #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned LATENCY = 3,
    parameter int unsigned TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [2:0]       mulop,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  f,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned PW   = 2 * XLEN;
    localparam int unsigned NMID = (LATENCY > 1) ? LATENCY - 1 : 1;

    localparam logic [2:0] MUL_OP     = 3'd0;
    localparam logic [2:0] MUL_OP_HSU = 3'd2;
    localparam logic [2:0] MUL_OP_HU  = 3'd3;

    localparam logic [1:0] CLS_SS = 2'd0;
    localparam logic [1:0] CLS_SU = 2'd1;
    localparam logic [1:0] CLS_UU = 2'd2;

    logic            w_stall;
    logic            w_acc;
    logic            w_hi;
    logic [1:0]      w_cls;
    logic [XLEN:0]   w_ax;
    logic [XLEN:0]   w_bx;
    logic [PW-1:0]   w_prod;
    logic            w_reuse_hit;

    logic             w_feed_vld;
    logic             w_feed_hi;
    logic [TAG_W-1:0] w_feed_tag;
    logic [PW-1:0]    w_feed_prod;

    logic [NMID-1:0]  r_vld;
    logic [NMID-1:0]  r_hi;
    logic [TAG_W-1:0] r_tag  [NMID];
    logic [PW-1:0]    r_prod [NMID];

    logic             r_out_valid;
    logic [XLEN-1:0]  r_f;
    logic [TAG_W-1:0] r_out_tag;

    // Operand extension class and full product of the incoming request
    always_comb begin
        w_hi  = (mulop != MUL_OP);
        w_cls = CLS_SS;
        case (mulop)
            MUL_OP_HSU: w_cls = CLS_SU;
            MUL_OP_HU:  w_cls = CLS_UU;
            default:    w_cls = CLS_SS;
        endcase
        w_ax   = {(w_cls != CLS_UU) && a[XLEN-1], a};
        w_bx   = {(w_cls == CLS_SS) && b[XLEN-1], b};
        w_prod = PW'($signed(w_ax)) * PW'($signed(w_bx));
    end

    always_comb begin
        w_stall  = r_out_valid && !out_ready;
        in_ready = !w_stall && !flush;
        w_acc    = in_valid && in_ready && !w_reuse_hit;
    end

    // Source feeding the output register: the last internal stage, or the request itself
    generate
        if (LATENCY == 1) begin : g_feed_in
            assign w_feed_vld  = w_acc;
            assign w_feed_hi   = w_hi;
            assign w_feed_tag  = in_tag;
            assign w_feed_prod = w_prod;
        end else begin : g_feed_stg
            assign w_feed_vld  = r_vld[NMID-1];
            assign w_feed_hi   = r_hi[NMID-1];
            assign w_feed_tag  = r_tag[NMID-1];
            assign w_feed_prod = r_prod[NMID-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld       <= '0;
            r_out_valid <= 1'b0;
            r_f         <= '0;
            r_out_tag   <= '0;
        end else if (flush) begin
            r_vld       <= '0;
            r_out_valid <= 1'b0;
        end else if (!w_stall) begin
            r_vld[0] <= w_acc;
            for (int i = 1; i < int'(NMID); i++) begin
                r_vld[i] <= r_vld[i-1];
            end
            r_out_valid <= w_feed_vld || w_reuse_hit;
            if (w_feed_vld) begin
                r_f       <= w_feed_hi ? w_feed_prod[PW-1:XLEN] : w_feed_prod[XLEN-1:0];
                r_out_tag <= w_feed_tag;
            end else if (w_reuse_hit) begin
                r_f       <= w_hi ? r_rp_sel_hi() : r_rp_sel_lo();
                r_out_tag <= in_tag;
            end
        end
    end

    // Stage payloads hold while stalled; validity lives in r_vld
    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_hi[0]   <= w_hi;
            r_tag[0]  <= in_tag;
            r_prod[0] <= w_prod;
            for (int i = 1; i < int'(NMID); i++) begin
                r_hi[i]   <= r_hi[i-1];
                r_tag[i]  <= r_tag[i-1];
                r_prod[i] <= r_prod[i-1];
            end
        end
    end

`ifdef MUL_PIPE_REUSE_EN
    logic            r_rv;
    logic [XLEN-1:0] r_ra;
    logic [XLEN-1:0] r_rb;
    logic [1:0]      r_rcls;
    logic [PW-1:0]   r_rp;

    // Operands are captured at accept; when the pipe is empty the last accepted
    // request is also the last one whose product reached the output.
    assign w_reuse_hit = in_valid && in_ready && r_rv && !r_out_valid && !(|r_vld)
                         && (a == r_ra) && (b == r_rb) && (w_cls == r_rcls);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rv   <= 1'b0;
            r_ra   <= '0;
            r_rb   <= '0;
            r_rcls <= CLS_SS;
            r_rp   <= '0;
        end else if (flush) begin
            r_rv <= 1'b0;
        end else if (!w_stall) begin
            if (in_valid && in_ready) begin
                r_ra   <= a;
                r_rb   <= b;
                r_rcls <= w_cls;
            end
            if (w_feed_vld) begin
                r_rp <= w_feed_prod;
                r_rv <= 1'b1;
            end
        end
    end

    function automatic logic [XLEN-1:0] r_rp_sel_hi();
        return r_rp[PW-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] r_rp_sel_lo();
        return r_rp[XLEN-1:0];
    endfunction
`else
    assign w_reuse_hit = 1'b0;

    function automatic logic [XLEN-1:0] r_rp_sel_hi();
        return '0;
    endfunction

    function automatic logic [XLEN-1:0] r_rp_sel_lo();
        return '0;
    endfunction
`endif

    assign out_valid = r_out_valid;
    assign f         = r_f;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe (XLEN=32, LATENCY=3): driver pushes expectations, monitor pops on output handshake.
module tb_mul_pipe;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned LATENCY = 3;
    localparam int unsigned TAG_W   = 5;
`ifdef MUL_PIPE_REUSE_EN
    localparam int REUSE_LAT = 1;
`else
    localparam int REUSE_LAT = 3;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [2:0]       mulop;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  f;
    logic [TAG_W-1:0] out_tag;

    mul_pipe #(.XLEN(XLEN), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mulop(mulop), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .f(f), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  f;
        int               cyc;
        int               stl;
        int               lat;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   n_vec     = 0;
    int   n_err     = 0;
    int   cyc       = 0;
    int   stall_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: unsigned product with sign corrections on the high half
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
        logic [63:0] p;
        logic [31:0] hi;
        p  = {32'd0, x} * {32'd0, y};
        hi = p[63:32];
        case (op)
            3'd0: return p[31:0];
            3'd3: return hi;
            3'd2: begin
                if (x[31]) hi = hi - y;
                return hi;
            end
            default: begin
                if (x[31]) hi = hi - y;
                if (y[31]) hi = hi - x;
                return hi;
            end
        endcase
    endfunction

    // Output monitor
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sb.delete();
        end else if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_output: got tag=%0d f=%h, expected no output", out_tag, f);
            end else begin
                e_mon = sb.pop_front();
                n_vec++;
                if (out_tag !== e_mon.tag) begin
                    n_err++;
                    $display("FAIL out_tag: got %0d, expected %0d", out_tag, e_mon.tag);
                end
                n_vec++;
                if (f !== e_mon.f) begin
                    n_err++;
                    $display("FAIL f tag=%0d: got %h, expected %h", e_mon.tag, f, e_mon.f);
                end
                n_vec++;
                if ((cyc - e_mon.cyc) !== (e_mon.lat + stall_cnt - e_mon.stl)) begin
                    n_err++;
                    $display("FAIL latency tag=%0d: got %0d, expected %0d", e_mon.tag,
                             cyc - e_mon.cyc, e_mon.lat + stall_cnt - e_mon.stl);
                end
            end
        end else if (out_valid) begin
            stall_cnt++;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic [2:0] op,
                        input logic [TAG_W-1:0] tg, input logic [31:0] ef, input int lat);
        exp_t e;
        int   g;
        g        = 0;
        in_valid = 1'b1;
        a        = ta;
        b        = tb_v;
        mulop    = op;
        in_tag   = tg;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout tag=%0d: got in_ready=0, expected 1", tg);
        end else begin
            e.tag = tg; e.f = ef; e.cyc = cyc; e.stl = stall_cnt; e.lat = lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
        n_vec++;
        if (f !== 32'h0) begin n_err++; $display("FAIL reset_f: got %h, expected 0", f); end
        n_vec++;
        if (out_tag !== 5'd0) begin n_err++; $display("FAIL reset_out_tag: got %0d, expected 0", out_tag); end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_ops();
        logic [31:0] va [9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] vb [9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        logic [2:0]  vo [9] = '{3'd1, 3'd3, 3'd2, 3'd0, 3'd1, 3'd1, 3'd0, 3'd7, 3'd5};
        logic [31:0] vf [9] = '{32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001,
                                32'h40000000, 32'h00000000, 32'h80000000, 32'h00000000, 32'h40000000};
        for (int i = 0; i < 9; i++) begin
            send(va[i], vb[i], vo[i], TAG_W'(i + 1), vf[i], LATENCY);
        end
        idle(6);
    endtask

    task automatic test_random();
        bit done;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    logic [31:0] ra, rb;
                    logic [2:0]  op;
                    ra = $urandom();
                    rb = (i % 5 == 0) ? 32'h7FFFFFFF : $urandom();
                    op = 3'($urandom_range(0, 7));
                    send(ra, rb, op, TAG_W'(i + 8), model(ra, rb, op), LATENCY);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        idle(10);
    endtask

    task automatic test_back_to_back_stall();
        logic [31:0] sa [5];
        logic [31:0] sbv [5];
        logic [31:0] e1;
        for (int i = 0; i < 5; i++) begin
            sa[i]  = $urandom();
            sbv[i] = $urandom();
        end
        e1 = model(sa[0], sbv[0], 3'd1);
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    send(sa[i], sbv[i], 3'd1, TAG_W'(i + 1), model(sa[i], sbv[i], 3'd1), LATENCY);
                end
            end
            begin
                int g;
                g = 0;
                @(negedge clk);
                while (!out_valid && g < 20) begin
                    @(negedge clk);
                    g++;
                end
                n_vec++;
                if (!out_valid) begin
                    n_err++;
                    $display("FAIL stall_first_valid: got out_valid=0, expected 1");
                end
                for (int k = 0; k < 4; k++) begin
                    if (k > 0) @(negedge clk);
                    n_vec++;
                    if (in_ready !== 1'b0) begin
                        n_err++;
                        $display("FAIL stall_in_ready cycle %0d: got %b, expected 0", k, in_ready);
                    end
                    n_vec++;
                    if (out_tag !== 5'd1 || f !== e1 || out_valid !== 1'b1) begin
                        n_err++;
                        $display("FAIL stall_hold cycle %0d: got v=%b tag=%0d f=%h, expected v=1 tag=1 f=%h",
                                 k, out_valid, out_tag, f, e1);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(8);
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(32'h1000 + 32'(i), 32'h33, 3'd0, TAG_W'(i + 20), model(32'h1000 + 32'(i), 32'h33, 3'd0), LATENCY);
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_tag   = 5'd9;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %b, expected 0", in_ready); end
        @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b, expected 0", out_valid); end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(32'h12345678, 32'h9, 3'd0, 5'd7, model(32'h12345678, 32'h9, 3'd0), LATENCY);
        idle(8);
    endtask

    task automatic test_reset_mid();
        send(32'hDEADBEEF, 32'h11, 3'd3, 5'd12, model(32'hDEADBEEF, 32'h11, 3'd3), LATENCY);
        send(32'hCAFEF00D, 32'h22, 3'd3, 5'd13, model(32'hCAFEF00D, 32'h22, 3'd3), LATENCY);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_vec++;
        if (out_valid !== 1'b0 || f !== 32'h0 || out_tag !== 5'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: got v=%b f=%h tag=%0d, expected v=0 f=0 tag=0", out_valid, f, out_tag);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL midreset_in_ready: got %b, expected 1", in_ready); end
        idle(8);
    endtask

    task automatic test_reuse();
        send(32'd7, 32'hFFFFFFFD, 3'd1, 5'd3, 32'hFFFFFFFF, LATENCY);
        idle(6);
        send(32'd7, 32'hFFFFFFFD, 3'd0, 5'd4, 32'hFFFFFFEB, REUSE_LAT);
        idle(6);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        mulop     = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_ops();
        test_random();
        test_back_to_back_stall();
        test_flush();
        test_reset_mid();
        test_reuse();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d outstanding results, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
